// File: rtl/frame_out_ctrl_p.sv
`default_nettype none
// ============================================================================
// Module      : frame_out_ctrl_p
// Description : Framed output controller. Pulls frame_length words from an
//               upstream FIFO and emits a continuous word stream of the form
//               [SYNC0 SYNC1] [seq_cnt] data... [checksum]. An idle gap of
//               blank_length cycles follows each frame. Run/stop requests
//               arrive asynchronously, and a stop takes effect only at a
//               frame boundary.
//
// Ports
//   clk           : sole clock, rising edge
//   reset_n       : asynchronous active-low reset
//   start_en      : async run request, rising edge arms output
//   stop_en       : async stop request, rising edge disarms output
//   head_en       : emit SYNC0/SYNC1 header pair
//   seq_en        : emit sequence-count word after header
//   sum_en        : emit checksum trailer after data
//   frame_length  : data words per frame
//   blank_length  : idle cycles after each frame
//   fifo_rdnum    : upstream FIFO fill level
//   dat_in        : FIFO read data, valid the cycle after rdacq
//   rdacq         : FIFO read strobe
//   en_out        : dat_out valid
//   dat_out       : output word stream
//   busy          : frame in progress (header through blank)
//   seq_cnt       : number of completed frames
//
// Revision    : 1.0  initial release
// ============================================================================
module frame_out_ctrl_p #(
    parameter int DATA_W  = 16,
    parameter int LEN_W   = 16,
    parameter int RDNUM_W = 13,
    parameter     SYNC0   = 16'h1ACF,
    parameter     SYNC1   = 16'hFC1D
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start_en,
    input  logic               stop_en,
    input  logic               head_en,
    input  logic               seq_en,
    input  logic               sum_en,
    input  logic [LEN_W-1:0]   frame_length,
    input  logic [LEN_W-1:0]   blank_length,
    input  logic [RDNUM_W-1:0] fifo_rdnum,
    input  logic [DATA_W-1:0]  dat_in,
    output logic               rdacq,
    output logic               en_out,
    output logic [DATA_W-1:0]  dat_out,
    output logic               busy,
    output logic [DATA_W-1:0]  seq_cnt
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [DATA_W-1:0] c_sync0   = DATA_W'(SYNC0);
    localparam logic [DATA_W-1:0] c_sync1   = DATA_W'(SYNC1);
    localparam int                c_cmp_w   = (LEN_W > RDNUM_W) ? LEN_W : RDNUM_W;
    localparam logic [LEN_W-1:0]  c_len_one = LEN_W'(1);
    localparam logic [DATA_W-1:0] c_dat_one = DATA_W'(1);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_wait  = 3'd1;
    localparam logic [2:0] c_st_head0 = 3'd2;
    localparam logic [2:0] c_st_head1 = 3'd3;
    localparam logic [2:0] c_st_seq   = 3'd4;
    localparam logic [2:0] c_st_data  = 3'd5;
    localparam logic [2:0] c_st_sum   = 3'd6;
    localparam logic [2:0] c_st_blank = 3'd7;

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic [2:0]         r_start_sync;   // [1:0] synchroniser, [2] edge history
    logic [2:0]         r_stop_sync;
    logic               w_start_edge;
    logic               w_stop_edge;
    logic               r_run;

    logic [c_cmp_w-1:0] w_rdnum_ext;
    logic [c_cmp_w-1:0] w_len_ext;
    logic               r_fifo_ok;

    logic [2:0]         r_state;
    logic [2:0]         w_state_next;
    logic               r_wait_armed;
    logic               w_go;

    logic [LEN_W-1:0]   r_cnt;
    logic [LEN_W-1:0]   r_blank;
    logic               r_seq_en;
    logic               r_sum_en;

    logic               w_emit;
    logic               w_last;
    logic               r_p1_en;
    logic [2:0]         r_p1_sel;
    logic               r_p1_last;
    logic [DATA_W-1:0]  w_word;

    logic               r_rdacq;
    logic               r_busy;
    logic               r_en_out;
    logic               r_last_out;
    logic [DATA_W-1:0]  r_dat_out;
    logic [DATA_W-1:0]  r_chk;
    logic [DATA_W-1:0]  r_seq_cnt;

    // ------------------------------------------------------------------------
    // Run/stop request synchronisers and run flag
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_start_sync <= 3'b000;
            r_stop_sync  <= 3'b000;
        end else begin
            r_start_sync <= {r_start_sync[1:0], start_en};
            r_stop_sync  <= {r_stop_sync[1:0], stop_en};
        end
    end

    assign w_start_edge = r_start_sync[1] & ~r_start_sync[2];
    assign w_stop_edge  = r_stop_sync[1]  & ~r_stop_sync[2];

    // Stop has priority when both edges land in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_run <= 1'b0;
        end else if (w_stop_edge) begin
            r_run <= 1'b0;
        end else if (w_start_edge) begin
            r_run <= 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // FIFO level qualification. Both operands are zero-extended to a common
    // width so a frame_length beyond the FIFO count range can never qualify.
    // ------------------------------------------------------------------------
    assign w_rdnum_ext = c_cmp_w'(fifo_rdnum);
    assign w_len_ext   = c_cmp_w'(frame_length);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fifo_ok <= 1'b0;
        end else begin
            r_fifo_ok <= (w_rdnum_ext >= w_len_ext) && (frame_length != '0);
        end
    end

    // ------------------------------------------------------------------------
    // Frame state machine
    // ------------------------------------------------------------------------
    // WAIT always dwells at least one cycle before launching a frame, so the
    // FIFO level is re-qualified after the previous frame's last read. This
    // dwell plus the blank period forms the blank_length+2 inter-frame gap.
    assign w_go = (r_state == c_st_wait) && r_run && r_fifo_ok && r_wait_armed;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: begin
                w_state_next = c_st_wait;
            end
            c_st_wait: begin
                if (w_go) begin
                    if (head_en) begin
                        w_state_next = c_st_head0;
                    end else if (seq_en) begin
                        w_state_next = c_st_seq;
                    end else begin
                        w_state_next = c_st_data;
                    end
                end
            end
            c_st_head0: begin
                w_state_next = c_st_head1;
            end
            c_st_head1: begin
                w_state_next = r_seq_en ? c_st_seq : c_st_data;
            end
            c_st_seq: begin
                w_state_next = c_st_data;
            end
            c_st_data: begin
                if (r_cnt == '0) begin
                    if (r_sum_en) begin
                        w_state_next = c_st_sum;
                    end else if (r_blank != '0) begin
                        w_state_next = c_st_blank;
                    end else begin
                        w_state_next = c_st_wait;
                    end
                end
            end
            c_st_sum: begin
                w_state_next = (r_blank != '0) ? c_st_blank : c_st_wait;
            end
            c_st_blank: begin
                if (r_cnt == '0) begin
                    w_state_next = c_st_wait;
                end
            end
            default: begin
                w_state_next = c_st_idle;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Per-frame configuration latch and shared data/blank down-counter.
    // The counter holds remaining DATA cycles, then is reloaded on the last
    // data word with the remaining BLANK cycles (SUM does not touch it).
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wait_armed <= 1'b0;
            r_cnt        <= '0;
            r_blank      <= '0;
            r_seq_en     <= 1'b0;
            r_sum_en     <= 1'b0;
        end else begin
            r_wait_armed <= (r_state == c_st_wait);
            if (w_go) begin
                r_cnt    <= frame_length - c_len_one;
                r_blank  <= blank_length;
                r_seq_en <= seq_en;
                r_sum_en <= sum_en;
            end else if (r_state == c_st_data) begin
                if (r_cnt == '0) begin
                    r_cnt <= r_blank - c_len_one;
                end else begin
                    r_cnt <= r_cnt - c_len_one;
                end
            end else if (r_state == c_st_blank) begin
                r_cnt <= r_cnt - c_len_one;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output pipeline. Each word-state cycle reaches dat_out two cycles later:
    // stage 1 records which word to send (and, for data, waits for the FIFO
    // read data), stage 2 registers the word. rdacq is high in the DATA-state
    // cycles themselves, so each read word lands exactly two cycles after its
    // strobe and the stream has no bubbles across header/data/trailer.
    // ------------------------------------------------------------------------
    assign w_emit = (r_state == c_st_head0) || (r_state == c_st_head1) ||
                    (r_state == c_st_seq)   || (r_state == c_st_data)  ||
                    (r_state == c_st_sum);

    assign w_last = ((r_state == c_st_data) && (r_cnt == '0) && !r_sum_en) ||
                    (r_state == c_st_sum);

    always_comb begin
        w_word = r_dat_out;
        case (r_p1_sel)
            c_st_head0: w_word = c_sync0;
            c_st_head1: w_word = c_sync1;
            c_st_seq:   w_word = r_seq_cnt;
            c_st_data:  w_word = dat_in;
            c_st_sum:   w_word = r_chk;
            default:    w_word = r_dat_out;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rdacq    <= 1'b0;
            r_busy     <= 1'b0;
            r_p1_en    <= 1'b0;
            r_p1_sel   <= c_st_idle;
            r_p1_last  <= 1'b0;
            r_en_out   <= 1'b0;
            r_last_out <= 1'b0;
            r_dat_out  <= '0;
        end else begin
            r_rdacq    <= (w_state_next == c_st_data);
            r_busy     <= (w_state_next != c_st_idle) && (w_state_next != c_st_wait);
            r_p1_en    <= w_emit;
            r_p1_sel   <= r_state;
            r_p1_last  <= w_last;
            r_en_out   <= r_p1_en;
            r_last_out <= r_p1_en && r_p1_last;
            // dat_out holds its last word whenever the stream is idle.
            if (r_p1_en) begin
                r_dat_out <= w_word;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Checksum over data words only, cleared at frame launch. The last data
    // word is accumulated one cycle before the trailer is registered.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_chk <= '0;
        end else if (w_go) begin
            r_chk <= '0;
        end else if (r_p1_en && (r_p1_sel == c_st_data)) begin
            r_chk <= r_chk + dat_in;
        end
    end

    // Completed-frame counter, advances right after the final word is shown.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_seq_cnt <= '0;
        end else if (r_last_out) begin
            r_seq_cnt <= r_seq_cnt + c_dat_one;
        end
    end

    assign rdacq   = r_rdacq;
    assign en_out  = r_en_out;
    assign dat_out = r_dat_out;
    assign busy    = r_busy;
    assign seq_cnt = r_seq_cnt;

endmodule
`default_nettype wire

// File: tb/tb_frame_out_ctrl_p.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_out_ctrl_p
// Description : Directed self-checking bench for frame_out_ctrl_p. A FIFO
//               model answers rdacq with queued words one cycle later and
//               a monitor collects the output stream, gaps and run lengths.
// Revision    : 1.0  initial release
// ============================================================================
module tb_frame_out_ctrl_p;

    localparam int DW = 16;
    localparam int LW = 16;
    localparam int RW = 13;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start_en;
    logic          stop_en;
    logic          head_en;
    logic          seq_en;
    logic          sum_en;
    logic [LW-1:0] frame_length;
    logic [LW-1:0] blank_length;
    logic [RW-1:0] fifo_rdnum;
    logic [DW-1:0] dat_in;
    logic          rdacq;
    logic          en_out;
    logic [DW-1:0] dat_out;
    logic          busy;
    logic [DW-1:0] seq_cnt;

    int checks = 0;
    int errors = 0;

    // FIFO model and monitor state
    int            cyc;
    bit            pend_v;
    logic [DW-1:0] pend_d;
    logic [DW-1:0] auto_val;
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] out_q[$];
    int            out_cyc[$];
    int            gaps[$];
    int            runs[$];
    int            en_cnt, rd_cnt, rd_first, gap_len, run_len, hold_err;
    bit            prev_en, have_frame;
    logic [DW-1:0] last_dat;

    frame_out_ctrl_p #(
        .DATA_W (DW),
        .LEN_W  (LW),
        .RDNUM_W(RW),
        .SYNC0  (16'h1ACF),
        .SYNC1  (16'hFC1D)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start_en    (start_en),
        .stop_en     (stop_en),
        .head_en     (head_en),
        .seq_en      (seq_en),
        .sum_en      (sum_en),
        .frame_length(frame_length),
        .blank_length(blank_length),
        .fifo_rdnum  (fifo_rdnum),
        .dat_in      (dat_in),
        .rdacq       (rdacq),
        .en_out      (en_out),
        .dat_out     (dat_out),
        .busy        (busy),
        .seq_cnt     (seq_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_mon();
        out_q.delete();
        out_cyc.delete();
        gaps.delete();
        runs.delete();
        en_cnt     = 0;
        rd_cnt     = 0;
        rd_first   = -1;
        gap_len    = 0;
        run_len    = 0;
        hold_err   = 0;
        have_frame = 1'b0;
        prev_en    = en_out;
        last_dat   = dat_out;
    endtask

    // One clock: sample mid-cycle, serve the FIFO, record the stream.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (pend_v) dat_in = pend_d;
        pend_v = 1'b0;
        if (rdacq === 1'b1) begin
            pend_v = 1'b1;
            if (fifo_q.size() > 0) begin
                pend_d = fifo_q.pop_front();
            end else begin
                pend_d   = auto_val;
                auto_val = auto_val + 16'd1;
            end
            rd_cnt++;
            if (rd_first < 0) rd_first = cyc;
        end
        if (en_out === 1'b1) begin
            en_cnt++;
            if (!prev_en && have_frame) gaps.push_back(gap_len);
            run_len = prev_en ? run_len + 1 : 1;
            out_q.push_back(dat_out);
            out_cyc.push_back(cyc);
        end else begin
            if (prev_en) begin
                runs.push_back(run_len);
                have_frame = 1'b1;
                gap_len    = 0;
            end
            gap_len++;
            if (dat_out !== last_dat) hold_err++;
        end
        last_dat = dat_out;
        prev_en  = (en_out === 1'b1);
    endtask

    task automatic pulse_start();
        start_en = 1'b1;
        repeat (2) tick();
        start_en = 1'b0;
    endtask

    task automatic pulse_stop();
        stop_en = 1'b1;
        repeat (2) tick();
        stop_en = 1'b0;
    endtask

    task automatic wait_busy(input int budget, input string tag);
        int n = 0;
        while (busy !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk(tag, busy, 1);
    endtask

    task automatic wait_rdacq(input int budget, input string tag);
        int n = 0;
        while (rd_cnt == 0 && n < budget) begin
            tick();
            n++;
        end
        chk(tag, (rd_cnt > 0), 1);
    endtask

    initial begin
        logic [DW-1:0] exp1 [6];
        logic [DW-1:0] exp2 [5];
        int n;

        cyc          = 0;
        pend_v       = 1'b0;
        pend_d       = '0;
        auto_val     = 16'h0100;
        reset_n      = 1'b0;
        start_en     = 1'b0;
        stop_en      = 1'b0;
        head_en      = 1'b0;
        seq_en       = 1'b0;
        sum_en       = 1'b0;
        frame_length = '0;
        blank_length = '0;
        fifo_rdnum   = '0;
        dat_in       = '0;
        clr_mon();

        // ---------------- reset state ----------------
        repeat (3) tick();
        chk("rst_en_out",  en_out,  0);
        chk("rst_rdacq",   rdacq,   0);
        chk("rst_busy",    busy,    0);
        chk("rst_dat_out", dat_out, 0);
        chk("rst_seq_cnt", seq_cnt, 0);
        reset_n = 1'b1;
        clr_mon();
        repeat (10) tick();
        chk("idle_no_output", en_cnt + rd_cnt, 0);

        // ---------------- header + 4 data words ----------------
        head_en = 1'b1; seq_en = 1'b0; sum_en = 1'b0;
        frame_length = 16'd4; blank_length = 16'd3; fifo_rdnum = 13'd100;
        clr_mon();
        for (int i = 1; i <= 4; i++) fifo_q.push_back(DW'(i));
        pulse_start();
        wait_busy(20, "t1_busy");
        pulse_stop();
        repeat (40) tick();
        exp1 = '{16'h1ACF, 16'hFC1D, 16'h0001, 16'h0002, 16'h0003, 16'h0004};
        chk("t1_word_count", out_q.size(), 6);
        for (int i = 0; i < 6; i++) chk($sformatf("t1_word%0d", i), out_q[i], exp1[i]);
        chk("t1_rdacq_cycles", rd_cnt, 4);
        chk("t1_en_run", runs[0], 6);
        chk("t1_rd_to_out_latency", out_cyc[2] - rd_first, 2);
        chk("t1_seq_cnt", seq_cnt, 1);
        chk("t1_busy_end", busy, 0);

        // ---------------- seq + checksum, wrap in sum ----------------
        reset_n = 1'b0;
        tick();
        chk("t2_rst_seq_cnt", seq_cnt, 0);
        reset_n = 1'b1;
        repeat (3) tick();
        head_en = 1'b0; seq_en = 1'b1; sum_en = 1'b1;
        frame_length = 16'd3; blank_length = 16'd2;
        clr_mon();
        fifo_q.push_back(16'hFFFF);
        fifo_q.push_back(16'h0002);
        fifo_q.push_back(16'h0001);
        pulse_start();
        wait_busy(20, "t2_busy");
        pulse_stop();
        repeat (40) tick();
        exp2 = '{16'h0000, 16'hFFFF, 16'h0002, 16'h0001, 16'h0002};
        chk("t2_word_count", out_q.size(), 5);
        for (int i = 0; i < 5; i++) chk($sformatf("t2_word%0d", i), out_q[i], exp2[i]);
        chk("t2_rdacq_cycles", rd_cnt, 3);
        chk("t2_seq_cnt", seq_cnt, 1);

        // ---------------- continuous frames, gap = blank+2 ----------------
        head_en = 1'b1; seq_en = 1'b1; sum_en = 1'b0;
        frame_length = 16'd2; blank_length = 16'd5;
        clr_mon();
        pulse_start();
        n = 0;
        while (gaps.size() < 2 && n < 200) begin
            tick();
            n++;
        end
        chk("t3_two_gaps_seen", (gaps.size() >= 2), 1);
        pulse_stop();
        repeat (60) tick();
        chk("t3_gap0", gaps[0], 7);
        chk("t3_gap1", gaps[1], 7);
        chk("t3_run0", runs[0], 5);
        chk("t3_run1", runs[1], 5);
        chk("t3_seq_word_f0", out_q[2], 1);
        chk("t3_seq_word_f1", out_q[7], 2);
        chk("t3_whole_frames", out_q.size() % 5, 0);
        chk("t3_seq_cnt", seq_cnt, 1 + out_q.size() / 5);
        chk("t3_hold_when_idle", hold_err, 0);

        // ---------------- FIFO level gating ----------------
        head_en = 1'b0; seq_en = 1'b0; sum_en = 1'b0;
        frame_length = 16'd4; blank_length = 16'd4; fifo_rdnum = 13'd3;
        clr_mon();
        pulse_start();
        repeat (15) tick();
        chk("t4_no_rdacq", rd_cnt, 0);
        chk("t4_no_en_out", en_cnt, 0);
        for (int i = 0; i < 4; i++) fifo_q.push_back(DW'(16'h000A + i));
        fifo_rdnum = 13'd4;
        wait_rdacq(3, "t4_start_within_3");
        pulse_stop();
        repeat (30) tick();
        chk("t4_word_count", out_q.size(), 4);
        chk("t4_word0", out_q[0], 16'h000A);
        chk("t4_word3", out_q[3], 16'h000D);

        // ---------------- stop mid-data, checksum wrap ----------------
        head_en = 1'b0; seq_en = 1'b0; sum_en = 1'b1;
        frame_length = 16'd8; blank_length = 16'd2; fifo_rdnum = 13'd100;
        clr_mon();
        for (int i = 1; i <= 8; i++) fifo_q.push_back(DW'(16'h2000 + i));
        pulse_start();
        wait_rdacq(20, "t5_data_started");
        repeat (2) tick();
        pulse_stop();
        repeat (40) tick();
        chk("t5_word_count", out_q.size(), 9);
        chk("t5_first_data", out_q[0], 16'h2001);
        chk("t5_last_data", out_q[7], 16'h2008);
        chk("t5_checksum", out_q[8], 16'h0024);
        chk("t5_rdacq_cycles", rd_cnt, 8);
        chk("t5_busy_end", busy, 0);
        clr_mon();
        repeat (30) tick();
        chk("t5_no_more_frames", en_cnt + rd_cnt, 0);

        // simultaneous start and stop: stop wins
        clr_mon();
        start_en = 1'b1;
        stop_en  = 1'b1;
        repeat (2) tick();
        start_en = 1'b0;
        stop_en  = 1'b0;
        repeat (30) tick();
        chk("t5_start_stop_same", en_cnt + rd_cnt, 0);

        // ---------------- reset during DATA ----------------
        head_en = 1'b1; seq_en = 1'b0; sum_en = 1'b0;
        frame_length = 16'd6; blank_length = 16'd1;
        clr_mon();
        pulse_start();
        wait_rdacq(20, "t6_data_started");
        repeat (2) tick();
        chk("t6_pre_en_out", en_out, 1);
        reset_n = 1'b0;
        #1;
        chk("t6_rst_en_out",  en_out,  0);
        chk("t6_rst_rdacq",   rdacq,   0);
        chk("t6_rst_busy",    busy,    0);
        chk("t6_rst_dat_out", dat_out, 0);
        chk("t6_rst_seq_cnt", seq_cnt, 0);
        tick();
        reset_n = 1'b1;
        clr_mon();
        repeat (40) tick();
        chk("t6_no_output_after_rst", en_cnt + rd_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
